// File: rtl/kt_add_pipe.sv
// W_t + K_t adder for the SHA-2 core: 80-entry K ROM, round counter, 1- or 2-stage stalling pipe.
// Optional build macro KT_ADD_ROUND_OUT_EN adds the m_round output (round index of the output word).
module kt_add_pipe #(
   parameter int PIPE_STAGES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        s_mode64,
   input  logic [63:0] s_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [63:0] m_data,
   output logic        m_last,
`ifdef KT_ADD_ROUND_OUT_EN
   output logic [6:0]  m_round,
`endif
   output logic        m_mode64
);

   function automatic logic [63:0] kt_rom(input logic [6:0] t);
      case (t)
         7'd0:  kt_rom = 64'h428a2f98d728ae22;  7'd1:  kt_rom = 64'h7137449123ef65cd;
         7'd2:  kt_rom = 64'hb5c0fbcfec4d3b2f;  7'd3:  kt_rom = 64'he9b5dba58189dbbc;
         7'd4:  kt_rom = 64'h3956c25bf348b538;  7'd5:  kt_rom = 64'h59f111f1b605d019;
         7'd6:  kt_rom = 64'h923f82a4af194f9b;  7'd7:  kt_rom = 64'hab1c5ed5da6d8118;
         7'd8:  kt_rom = 64'hd807aa98a3030242;  7'd9:  kt_rom = 64'h12835b0145706fbe;
         7'd10: kt_rom = 64'h243185be4ee4b28c;  7'd11: kt_rom = 64'h550c7dc3d5ffb4e2;
         7'd12: kt_rom = 64'h72be5d74f27b896f;  7'd13: kt_rom = 64'h80deb1fe3b1696b1;
         7'd14: kt_rom = 64'h9bdc06a725c71235;  7'd15: kt_rom = 64'hc19bf174cf692694;
         7'd16: kt_rom = 64'he49b69c19ef14ad2;  7'd17: kt_rom = 64'hefbe4786384f25e3;
         7'd18: kt_rom = 64'h0fc19dc68b8cd5b5;  7'd19: kt_rom = 64'h240ca1cc77ac9c65;
         7'd20: kt_rom = 64'h2de92c6f592b0275;  7'd21: kt_rom = 64'h4a7484aa6ea6e483;
         7'd22: kt_rom = 64'h5cb0a9dcbd41fbd4;  7'd23: kt_rom = 64'h76f988da831153b5;
         7'd24: kt_rom = 64'h983e5152ee66dfab;  7'd25: kt_rom = 64'ha831c66d2db43210;
         7'd26: kt_rom = 64'hb00327c898fb213f;  7'd27: kt_rom = 64'hbf597fc7beef0ee4;
         7'd28: kt_rom = 64'hc6e00bf33da88fc2;  7'd29: kt_rom = 64'hd5a79147930aa725;
         7'd30: kt_rom = 64'h06ca6351e003826f;  7'd31: kt_rom = 64'h142929670a0e6e70;
         7'd32: kt_rom = 64'h27b70a8546d22ffc;  7'd33: kt_rom = 64'h2e1b21385c26c926;
         7'd34: kt_rom = 64'h4d2c6dfc5ac42aed;  7'd35: kt_rom = 64'h53380d139d95b3df;
         7'd36: kt_rom = 64'h650a73548baf63de;  7'd37: kt_rom = 64'h766a0abb3c77b2a8;
         7'd38: kt_rom = 64'h81c2c92e47edaee6;  7'd39: kt_rom = 64'h92722c851482353b;
         7'd40: kt_rom = 64'ha2bfe8a14cf10364;  7'd41: kt_rom = 64'ha81a664bbc423001;
         7'd42: kt_rom = 64'hc24b8b70d0f89791;  7'd43: kt_rom = 64'hc76c51a30654be30;
         7'd44: kt_rom = 64'hd192e819d6ef5218;  7'd45: kt_rom = 64'hd69906245565a910;
         7'd46: kt_rom = 64'hf40e35855771202a;  7'd47: kt_rom = 64'h106aa07032bbd1b8;
         7'd48: kt_rom = 64'h19a4c116b8d2d0c8;  7'd49: kt_rom = 64'h1e376c085141ab53;
         7'd50: kt_rom = 64'h2748774cdf8eeb99;  7'd51: kt_rom = 64'h34b0bcb5e19b48a8;
         7'd52: kt_rom = 64'h391c0cb3c5c95a63;  7'd53: kt_rom = 64'h4ed8aa4ae3418acb;
         7'd54: kt_rom = 64'h5b9cca4f7763e373;  7'd55: kt_rom = 64'h682e6ff3d6b2b8a3;
         7'd56: kt_rom = 64'h748f82ee5defb2fc;  7'd57: kt_rom = 64'h78a5636f43172f60;
         7'd58: kt_rom = 64'h84c87814a1f0ab72;  7'd59: kt_rom = 64'h8cc702081a6439ec;
         7'd60: kt_rom = 64'h90befffa23631e28;  7'd61: kt_rom = 64'ha4506cebde82bde9;
         7'd62: kt_rom = 64'hbef9a3f7b2c67915;  7'd63: kt_rom = 64'hc67178f2e372532b;
         7'd64: kt_rom = 64'hca273eceea26619c;  7'd65: kt_rom = 64'hd186b8c721c0c207;
         7'd66: kt_rom = 64'heada7dd6cde0eb1e;  7'd67: kt_rom = 64'hf57d4f7fee6ed178;
         7'd68: kt_rom = 64'h06f067aa72176fba;  7'd69: kt_rom = 64'h0a637dc5a2c898a6;
         7'd70: kt_rom = 64'h113f9804bef90dae;  7'd71: kt_rom = 64'h1b710b35131c471b;
         7'd72: kt_rom = 64'h28db77f523047d84;  7'd73: kt_rom = 64'h32caab7b40c72493;
         7'd74: kt_rom = 64'h3c9ebe0a15c9bebc;  7'd75: kt_rom = 64'h431d67c49c100d4c;
         7'd76: kt_rom = 64'h4cc5d4becb3e42b6;  7'd77: kt_rom = 64'h597f299cfc657e2a;
         7'd78: kt_rom = 64'h5fcb6fab3ad6faec;  7'd79: kt_rom = 64'h6c44198c4a475817;
         default: kt_rom = 64'h0;
      endcase
   endfunction

   logic [6:0]  t_r;
   logic        mode_r;
   logic        advance_s;
   logic        hs_s;
   logic        cur_mode_s;
   logic        cur_last_s;
   logic [63:0] k_s;
   logic [32:0] lo_sum_s;

   logic        out_valid_r;
   logic [63:0] out_data_r;
   logic        out_last_r;
   logic        out_mode_r;
`ifdef KT_ADD_ROUND_OUT_EN
   logic [6:0]  out_round_r;
   assign m_round = out_round_r;
`endif

   assign advance_s = ~out_valid_r | m_ready;
   assign s_ready   = advance_s & ~clr;
   assign hs_s      = s_valid & s_ready;
   assign m_valid   = out_valid_r;
   assign m_data    = out_data_r;
   assign m_last    = out_last_r;
   assign m_mode64  = out_mode_r;

   // K lookup, effective mode (live input at round 0) and the low-half sum
   always_comb begin
      k_s = kt_rom(t_r);
      if (t_r == 7'd0) begin
         cur_mode_s = s_mode64;
      end else begin
         cur_mode_s = mode_r;
      end
      if (cur_mode_s) begin
         cur_last_s = (t_r == 7'd79);
         lo_sum_s   = {1'b0, s_data[31:0]} + {1'b0, k_s[31:0]};
      end else begin
         cur_last_s = (t_r == 7'd63);
         lo_sum_s   = {1'b0, s_data[31:0]} + {1'b0, k_s[63:32]};
      end
   end

   // round counter and per-block mode latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_r    <= 7'd0;
         mode_r <= 1'b0;
      end else if (clr) begin
         t_r <= 7'd0;
      end else if (hs_s) begin
         if (t_r == 7'd0) begin
            mode_r <= s_mode64;
         end
         t_r <= cur_last_s ? 7'd0 : t_r + 7'd1;
      end
   end

   generate
      if (PIPE_STAGES == 2) begin : g_two
         logic        v1_r;
         logic [31:0] lo1_r;
         logic        c1_r;
         logic [31:0] w_hi1_r;
         logic [31:0] k_hi1_r;
         logic        mode1_r;
         logic        last1_r;
         logic [31:0] hi_s;
         logic [63:0] sum_s;
`ifdef KT_ADD_ROUND_OUT_EN
         logic [6:0]  round1_r;
`endif

         // stage 1: low half sum plus carry, high operands forwarded
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v1_r    <= 1'b0;
               lo1_r   <= 32'h0;
               c1_r    <= 1'b0;
               w_hi1_r <= 32'h0;
               k_hi1_r <= 32'h0;
               mode1_r <= 1'b0;
               last1_r <= 1'b0;
`ifdef KT_ADD_ROUND_OUT_EN
               round1_r <= 7'd0;
`endif
            end else if (clr) begin
               v1_r <= 1'b0;
            end else if (advance_s) begin
               v1_r <= hs_s;
               if (hs_s) begin
                  lo1_r   <= lo_sum_s[31:0];
                  c1_r    <= lo_sum_s[32];
                  w_hi1_r <= s_data[63:32];
                  k_hi1_r <= k_s[63:32];
                  mode1_r <= cur_mode_s;
                  last1_r <= cur_last_s;
`ifdef KT_ADD_ROUND_OUT_EN
                  round1_r <= t_r;
`endif
               end
            end
         end

         // high half: the low carry only counts in 64-bit mode
         always_comb begin
            hi_s = w_hi1_r + k_hi1_r + {31'd0, c1_r & mode1_r};
            if (mode1_r) begin
               sum_s = {hi_s, lo1_r};
            end else begin
               sum_s = {32'h0, lo1_r};
            end
         end

         // stage 2: output register
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_valid_r <= 1'b0;
               out_data_r  <= 64'h0;
               out_last_r  <= 1'b0;
               out_mode_r  <= 1'b0;
`ifdef KT_ADD_ROUND_OUT_EN
               out_round_r <= 7'd0;
`endif
            end else if (clr) begin
               out_valid_r <= 1'b0;
            end else if (advance_s) begin
               out_valid_r <= v1_r;
               if (v1_r) begin
                  out_data_r <= sum_s;
                  out_last_r <= last1_r;
                  out_mode_r <= mode1_r;
`ifdef KT_ADD_ROUND_OUT_EN
                  out_round_r <= round1_r;
`endif
               end
            end
         end
      end else begin : g_one
         logic [31:0] hi_s;
         logic [63:0] sum_s;

         // full add in one stage; high half sees the carry only in 64-bit mode
         always_comb begin
            hi_s = s_data[63:32] + k_s[63:32] + {31'd0, lo_sum_s[32]};
            if (cur_mode_s) begin
               sum_s = {hi_s, lo_sum_s[31:0]};
            end else begin
               sum_s = {32'h0, lo_sum_s[31:0]};
            end
         end

         // single output register
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_valid_r <= 1'b0;
               out_data_r  <= 64'h0;
               out_last_r  <= 1'b0;
               out_mode_r  <= 1'b0;
`ifdef KT_ADD_ROUND_OUT_EN
               out_round_r <= 7'd0;
`endif
            end else if (clr) begin
               out_valid_r <= 1'b0;
            end else if (advance_s) begin
               out_valid_r <= hs_s;
               if (hs_s) begin
                  out_data_r <= sum_s;
                  out_last_r <= cur_last_s;
                  out_mode_r <= cur_mode_s;
`ifdef KT_ADD_ROUND_OUT_EN
                  out_round_r <= t_r;
`endif
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_kt_add_pipe.sv
// Directed bench for kt_add_pipe: one instance with PIPE_STAGES=1 (index 0), one with 2 (index 1).
// Shared rst_n/clr/s_data/s_mode64; each instance has its own s_valid and m_ready.
module tb_kt_add_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             clr;
   logic             s_mode64;
   logic [63:0]      s_data;
   logic [1:0]       s_valid_v;
   logic [1:0]       s_ready_v;
   logic [1:0]       m_valid_v;
   logic [1:0]       m_ready_v;
   logic [1:0]       m_last_v;
   logic [1:0]       m_mode_v;
   logic [1:0][63:0] m_data_v;
`ifdef KT_ADD_ROUND_OUT_EN
   logic [1:0][6:0]  m_round_v;
`endif

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic        mode;
      logic [6:0]  round;
   } out_t;

   out_t q0[$];
   out_t q1[$];

   logic [1:0]       hold_v;
   logic [1:0][63:0] prev_data;
   logic [1:0]       prev_last;
   logic             stall_done;

   // SHA-256 round constants (upper halves of the SHA-512 set)
   logic [31:0] k256 [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   kt_add_pipe #(.PIPE_STAGES(1)) u_p1 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .s_valid(s_valid_v[0]), .s_ready(s_ready_v[0]), .s_mode64(s_mode64), .s_data(s_data),
      .m_valid(m_valid_v[0]), .m_ready(m_ready_v[0]), .m_data(m_data_v[0]), .m_last(m_last_v[0]),
`ifdef KT_ADD_ROUND_OUT_EN
      .m_round(m_round_v[0]),
`endif
      .m_mode64(m_mode_v[0])
   );

   kt_add_pipe #(.PIPE_STAGES(2)) u_p2 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .s_valid(s_valid_v[1]), .s_ready(s_ready_v[1]), .s_mode64(s_mode64), .s_data(s_data),
      .m_valid(m_valid_v[1]), .m_ready(m_ready_v[1]), .m_data(m_data_v[1]), .m_last(m_last_v[1]),
`ifdef KT_ADD_ROUND_OUT_EN
      .m_round(m_round_v[1]),
`endif
      .m_mode64(m_mode_v[1])
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic out_t mk_out(input int d);
      out_t o;
      o.data  = m_data_v[d];
      o.last  = m_last_v[d];
      o.mode  = m_mode_v[d];
`ifdef KT_ADD_ROUND_OUT_EN
      o.round = m_round_v[d];
`else
      o.round = 7'd0;
`endif
      return o;
   endfunction

   // record each transfer and check that a stalled output holds
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst_n && hold_v[d]) begin
            check_eq("hold_valid", {63'd0, m_valid_v[d]}, 64'd1);
            check_eq("hold_data", m_data_v[d], prev_data[d]);
            check_eq("hold_last", {63'd0, m_last_v[d]}, {63'd0, prev_last[d]});
         end
         if (rst_n && m_valid_v[d] && m_ready_v[d]) begin
            if (d == 0) q0.push_back(mk_out(0));
            else        q1.push_back(mk_out(1));
         end
         hold_v[d]    <= rst_n & m_valid_v[d] & ~m_ready_v[d] & ~clr;
         prev_data[d] <= m_data_v[d];
         prev_last[d] <= m_last_v[d];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic qclear();
      q0.delete();
      q1.delete();
   endtask

   task automatic pop(input int d, output out_t o);
      int n = 0;
      while (qsize(d) == 0 && n < 50) begin
         step();
         n++;
      end
      if (qsize(d) == 0) begin
         check_eq("pop_timeout", 64'(qsize(d)), 64'd1);
         o = '0;
      end else if (d == 0) begin
         o = q0.pop_front();
      end else begin
         o = q1.pop_front();
      end
   endtask

   task automatic send(input int d, input logic mode, input logic [63:0] w);
      int n = 0;
      s_valid_v[d] = 1'b1;
      s_mode64     = mode;
      s_data       = w;
      @(negedge clk);
      while (!s_ready_v[d] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready_v[d]) check_eq("send_timeout", {63'd0, s_ready_v[d]}, 64'd1);
      step();
      s_valid_v[d] = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic one_word(input int d, input string tag, input logic mode, input logic [63:0] w,
                           input logic [63:0] exp);
      out_t o;
      do_clr();
      send(d, mode, w);
      pop(d, o);
      check_eq(tag, o.data, exp);
      check_eq({tag, "_last"}, {63'd0, o.last}, 64'd0);
      check_eq({tag, "_mode"}, {63'd0, o.mode}, {63'd0, mode});
   endtask

   initial begin
      out_t o;
      int   n;
      rst_n = 1'b0; clr = 1'b0; s_mode64 = 1'b0; s_data = 64'h0;
      s_valid_v = 2'b00; m_ready_v = 2'b11; stall_done = 1'b0;
      #12;
      for (int d = 0; d < 2; d++) begin
         check_eq("rst_valid", {63'd0, m_valid_v[d]}, 64'd0);
         check_eq("rst_data", m_data_v[d], 64'h0);
         check_eq("rst_last", {63'd0, m_last_v[d]}, 64'd0);
         check_eq("rst_mode", {63'd0, m_mode_v[d]}, 64'd0);
      end
      step();
      rst_n = 1'b1;
      #1;
      check_eq("rst_ready", {62'd0, s_ready_v}, 64'd3);

      // single-word arithmetic and latency on both depths
      for (int d = 0; d < 2; d++) begin
         do_clr();
         send(d, 1'b0, 64'h0);
         n = 0;
         while (!m_valid_v[d] && n < 10) begin
            step();
            n++;
         end
         check_eq("latency", 64'(n + 1), 64'(d + 1));
         pop(d, o);
         check_eq("m32_zero", o.data, 64'h00000000428a2f98);
         check_eq("m32_zero_last", {63'd0, o.last}, 64'd0);
         one_word(d, "m32_wrap", 1'b0, 64'hFFFFFFFFbd75d068, 64'h0);
         one_word(d, "m64_carry", 1'b1, 64'h0000000028d751de, 64'h428a2f9900000000);
         one_word(d, "m64_ones", 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h428a2f98d728ae21);
      end

      // full mode32 block followed back-to-back by a mode64 block; s_mode64 toggled off round 0
      for (int d = 0; d < 2; d++) begin
         do_clr();
         for (int i = 0; i < 64; i++) send(d, (i == 0) ? 1'b0 : 1'b1, 64'h0);
         for (int i = 0; i < 80; i++) send(d, (i == 0) ? 1'b1 : 1'b0, 64'h0);
         for (int i = 0; i < 64; i++) begin
            pop(d, o);
            check_eq("blk32_data", o.data, {32'h0, k256[i]});
            check_eq("blk32_last", {63'd0, o.last}, (i == 63) ? 64'd1 : 64'd0);
            check_eq("blk32_mode", {63'd0, o.mode}, 64'd0);
         end
         for (int i = 0; i < 80; i++) begin
            pop(d, o);
            if (i < 64) check_eq("blk64_hi", {32'h0, o.data[63:32]}, {32'h0, k256[i]});
            if (i == 0) check_eq("blk64_first", o.data, 64'h428a2f98d728ae22);
            if (i == 79) check_eq("blk64_final", o.data, 64'h6c44198c4a475817);
            check_eq("blk64_last", {63'd0, o.last}, (i == 79) ? 64'd1 : 64'd0);
            check_eq("blk64_mode", {63'd0, o.mode}, 64'd1);
         end
      end

      // random backpressure over a mode32 block
      for (int d = 0; d < 2; d++) begin
         do_clr();
         stall_done = 1'b0;
         fork
            begin
               for (int i = 0; i < 64; i++) send(d, 1'b0, {32'hdeadbeef, 32'(i)});
               stall_done = 1'b1;
            end
            begin
               while (!stall_done) begin
                  m_ready_v[d] = 1'($urandom_range(0, 1));
                  step();
               end
               m_ready_v[d] = 1'b1;
            end
         join
         for (int i = 0; i < 64; i++) begin
            pop(d, o);
            check_eq("stall_data", o.data, {32'h0, k256[i] + 32'(i)});
            check_eq("stall_last", {63'd0, o.last}, (i == 63) ? 64'd1 : 64'd0);
`ifdef KT_ADD_ROUND_OUT_EN
            check_eq("stall_round", {57'd0, o.round}, 64'(i));
`endif
         end
         repeat (4) step();
         check_eq("stall_nodup", 64'(qsize(d)), 64'd0);
      end

      // clr at t=10 together with s_valid
      for (int d = 0; d < 2; d++) begin
         do_clr();
         qclear();
         for (int i = 0; i < 10; i++) send(d, 1'b0, 64'h0);
         s_valid_v[d] = 1'b1;
         s_data = 64'h0;
         clr = 1'b1;
         #3;
         check_eq("clr_ready", {63'd0, s_ready_v[d]}, 64'd0);
         step();
         clr = 1'b0;
         s_valid_v[d] = 1'b0;
         check_eq("clr_empty", {63'd0, m_valid_v[d]}, 64'd0);
         repeat (3) step();
         n = qsize(d);
         check_eq("clr_count", 64'(n), (d == 0) ? 64'd10 : 64'd9);
         if (n > 0) check_eq("clr_lastword", (d == 0) ? q0[$].data : q1[$].data,
                             {32'h0, (d == 0) ? k256[9] : k256[8]});
         qclear();
         send(d, 1'b0, 64'h0);
         pop(d, o);
         check_eq("clr_k0", o.data, 64'h00000000428a2f98);
         repeat (4) step();
         check_eq("clr_nodup", 64'(qsize(d)), 64'd0);
      end

      // asynchronous reset in the middle of a stalled block
      do_clr();
      m_ready_v[1] = 1'b0;
      send(1, 1'b1, 64'h1);
      send(1, 1'b1, 64'h2);
      step();
      check_eq("pre_rst_valid", {63'd0, m_valid_v[1]}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check_eq("arst_valid", {63'd0, m_valid_v[d]}, 64'd0);
         check_eq("arst_data", m_data_v[d], 64'h0);
         check_eq("arst_last", {63'd0, m_last_v[d]}, 64'd0);
         check_eq("arst_mode", {63'd0, m_mode_v[d]}, 64'd0);
      end
      step();
      step();
      rst_n = 1'b1;
      m_ready_v = 2'b11;
      qclear();
      #1;
      check_eq("arst_ready", {62'd0, s_ready_v}, 64'd3);
      for (int d = 0; d < 2; d++) begin
         send(d, 1'b0, 64'h0);
         pop(d, o);
         check_eq("arst_k0", o.data, 64'h00000000428a2f98);
         check_eq("arst_k0_mode", {63'd0, o.mode}, 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
